// File: rtl/fir_inverse_deconv.sv
// Recursive deconvolver that undoes the 4-tap FIR (taps 2,4,6,8).
// Optional macro FIR_INV_SAT_EN: saturate out-of-range results to 0/255.
module fir_inverse_deconv #(
   parameter int unsigned C0_SHIFT = 1,
   parameter logic [7:0]  C1       = 8'd4,
   parameter logic [7:0]  C2       = 8'd6,
   parameter logic [7:0]  C3       = 8'd8
) (
   input  logic        clk,
   input  logic        res,
   input  logic [15:0] y_in,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   output logic [7:0]  x_out,
   output logic        out_valid,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAC1,
      S_MAC2,
      S_MAC3,
      S_RESOLVE
   } state_t;

   localparam logic [18:0] REM_MASK = 19'((19'd1 << C0_SHIFT) - 19'd1);

   state_t             r_state;
   state_t             w_next;
   logic signed [18:0] r_acc;
   logic [7:0]         r_h1;
   logic [7:0]         r_h2;
   logic [7:0]         r_h3;
   logic [7:0]         w_coef;
   logic [7:0]         w_hist;
   logic [15:0]        w_prod;
   logic signed [18:0] w_q;
   logic               w_rem_nz;
   logic               w_neg;
   logic               w_big;
   logic               w_err;
   logic [7:0]         w_x;

   assign in_ready = (r_state == S_IDLE);

   // State register; flush aborts back to IDLE.
   always_ff @(posedge clk) begin
      if (res || flush) r_state <= S_IDLE;
      else              r_state <= w_next;
   end

   // Next-state sequencing through the three MAC steps.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (in_valid) w_next = S_MAC1;
         S_MAC1:    w_next = S_MAC2;
         S_MAC2:    w_next = S_MAC3;
         S_MAC3:    w_next = S_RESOLVE;
         S_RESOLVE: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Operand select for the single shared multiplier.
   always_comb begin
      w_coef = C1;
      w_hist = r_h1;
      unique case (r_state)
         S_MAC2: begin
            w_coef = C2;
            w_hist = r_h2;
         end
         S_MAC3: begin
            w_coef = C3;
            w_hist = r_h3;
         end
         default: begin
            w_coef = C1;
            w_hist = r_h1;
         end
      endcase
   end

   assign w_prod   = w_coef * w_hist;
   assign w_q      = r_acc >>> C0_SHIFT;
   assign w_rem_nz = |(r_acc & REM_MASK);
   assign w_neg    = w_q[18];
   assign w_big    = !w_neg && (w_q > 19'sd255);
   assign w_err    = w_rem_nz || w_neg || w_big;

`ifdef FIR_INV_SAT_EN
   // Clamp to the 8-bit sample range.
   always_comb begin
      w_x = w_q[7:0];
      if (w_neg)      w_x = 8'd0;
      else if (w_big) w_x = 8'd255;
   end
`else
   // Two's-complement truncation of the quotient.
   always_comb begin
      w_x = w_q[7:0];
   end
`endif

   // Accumulator, history and output registers.
   always_ff @(posedge clk) begin
      if (res) begin
         r_acc     <= '0;
         r_h1      <= '0;
         r_h2      <= '0;
         r_h3      <= '0;
         x_out     <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         err       <= 1'b0;
         if (flush) begin
            r_acc <= '0;
            r_h1  <= '0;
            r_h2  <= '0;
            r_h3  <= '0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (in_valid) r_acc <= $signed({3'b000, y_in});
               end
               S_MAC1, S_MAC2, S_MAC3: begin
                  r_acc <= r_acc - $signed({3'b000, w_prod});
               end
               S_RESOLVE: begin
                  x_out     <= w_x;
                  err       <= w_err;
                  out_valid <= 1'b1;
                  r_h3      <= r_h2;
                  r_h2      <= r_h1;
                  r_h1      <= w_x;
               end
               default: r_acc <= r_acc;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fir_inverse_deconv.sv
// Scoreboard bench for fir_inverse_deconv.
// Expected samples are queued at accept time and checked on out_valid.
module tb_fir_inverse_deconv;

   logic        clk = 1'b0;
   logic        res;
   logic [15:0] y_in;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [7:0]  x_out;
   logic        out_valid;
   logic        err;

`ifdef FIR_INV_SAT_EN
   localparam int NEG_X = 0;
   localparam int OVF_X = 255;
`else
   localparam int NEG_X = 236;
   localparam int OVF_X = 44;
`endif

   typedef struct {
      int x;
      int e;
      int at;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   logic prev_ov  = 1'b0;
   int   base;

   fir_inverse_deconv dut (
      .clk       (clk),
      .res       (res),
      .y_in      (y_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .x_out     (x_out),
      .out_valid (out_valid),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, int act, int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, req, cyc);
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (out_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: x_out=%0d err=%0d expected none",
                     x_out, err);
         end else begin
            e = sb.pop_front();
            check("x_out", int'(x_out), e.x);
            check("err", int'(err), e.e);
            check("out_cycle", cyc, e.at);
         end
      end else if (prev_ov) begin
         check("err_clear", int'(err), 0);
      end
      prev_ov = out_valid;
   end

   task automatic send(input logic [15:0] y, input bit want,
                       input int ex, input int ee);
      int w = 0;
      @(negedge clk);
      y_in     = y;
      in_valid = 1'b1;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("accept", int'(in_ready), 1);
      if (in_ready && want) sb.push_back('{ex, ee, cyc + 5});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (sb.size() != 0 && w < 40) begin
         @(negedge clk);
         w++;
      end
      check("drain", sb.size(), 0);
      sb.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      @(negedge clk);
      res = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      res      = 1'b1;
      in_valid = 1'b0;
      flush    = 1'b0;
      y_in     = '0;
      repeat (3) @(negedge clk);
      res = 1'b0;
      @(negedge clk);
      check("rst_x_out", int'(x_out), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_err", int'(err), 0);
      check("rst_in_ready", int'(in_ready), 1);

      send(16'd20, 1, 10, 0);
      send(16'd80, 1, 20, 0);
      send(16'd200, 1, 30, 0);
      send(16'd320, 1, 0, 0);
      drain();

      do_reset();
      send(16'd21, 1, 10, 1);
      send(16'd40, 1, 0, 0);
      drain();

      do_reset();
      send(16'd20, 1, 10, 0);
      send(16'd0, 1, NEG_X, 1);
      drain();

      do_reset();
      send(16'd600, 1, OVF_X, 1);
      drain();

      do_reset();
      y_in     = 16'd0;
      in_valid = 1'b1;
      base     = cyc;
      sb.push_back('{0, 0, base + 5});
      sb.push_back('{0, 0, base + 10});
      sb.push_back('{0, 0, base + 15});
      repeat (15) @(negedge clk);
      in_valid = 1'b0;
      drain();
      repeat (6) @(negedge clk);

      do_reset();
      send(16'd20, 1, 10, 0);
      drain();
      send(16'd80, 0, 0, 0);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      repeat (8) @(negedge clk);
      send(16'd20, 1, 10, 0);
      drain();

      do_reset();
      send(16'd20, 1, 10, 0);
      drain();
      send(16'd80, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      check("mid_rst_x_out", int'(x_out), 0);
      check("mid_rst_out_valid", int'(out_valid), 0);
      check("mid_rst_err", int'(err), 0);
      check("mid_rst_in_ready", int'(in_ready), 1);
      repeat (6) @(negedge clk);
      send(16'd20, 1, 10, 0);
      drain();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
